// File: rtl/ddr_burst_engine.sv
// Responder for the DDR frame-buffer burst request/ack/finish handshake.
// Write bursts drain the requester's FIFO to the memory port; read bursts return data to it.
module ddr_burst_engine #(
    parameter int unsigned ADDR_W  = 25,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned LEN_W   = 10,
    parameter int unsigned HOLDOFF = 2
) (
    input  logic              clk_ref,
    input  logic              rst_n,
    input  logic              ddr_init_done,
    input  logic              ddr_wr_req,
    input  logic [ADDR_W-1:0] ddr_wraddr,
    input  logic [LEN_W-1:0]  wr_length,
    output logic              ddr_wr_ack,
    input  logic [DATA_W-1:0] ddr_din,
    output logic              ddr_wr_finish,
    input  logic              ddr_rd_req,
    input  logic [ADDR_W-1:0] ddr_rdaddr,
    input  logic [LEN_W-1:0]  rd_length,
    output logic              ddr_rd_ack,
    output logic [DATA_W-1:0] ddr_dout,
    output logic              ddr_rd_finish,
    output logic              mem_wr_en,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rdy,
    input  logic              mem_rd_valid,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              busy
);

    localparam int unsigned CW = LEN_W + 1;
    localparam int unsigned HW = $clog2(HOLDOFF + 2);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StWr   = 2'd1;
    localparam logic [1:0] StRd   = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    logic [1:0]        state_q, state_d;
    logic              is_wr_q, is_wr_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [CW-1:0]     len_q, len_d;
    // cnt_a: acks issued (write) / commands issued (read)
    // cnt_b: words written (write) / words returned (read)
    logic [CW-1:0]     cnt_a_q, cnt_a_d;
    logic [CW-1:0]     cnt_b_q, cnt_b_d;
    logic              ack_q;
    logic [1:0]        occ_q, occ_d;
    logic [DATA_W-1:0] buf0_q, buf0_d;
    logic [DATA_W-1:0] buf1_q, buf1_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic              rd_ack_q;
    logic [DATA_W-1:0] dout_q;

    logic wr_ack, wr_en, wr_pop, wr_push, rd_en, rd_accept;

    always_comb begin
        // Acks in flight count against buffer space, so the skid never overflows.
        wr_ack    = (state_q == StWr) && (cnt_a_q < len_q) &&
                    ((3'(occ_q) + 3'(ack_q)) < 3'd2);
        wr_en     = (state_q == StWr) && (occ_q != 2'd0);
        wr_pop    = wr_en && mem_rdy;
        wr_push   = (state_q == StWr) && ack_q;
        rd_en     = (state_q == StRd) && (cnt_a_q < len_q);
        rd_accept = (state_q == StRd) && mem_rd_valid && (cnt_b_q < len_q);
    end

    always_comb begin
        state_d = state_q;
        is_wr_d = is_wr_q;
        base_d  = base_q;
        len_d   = len_q;
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;
        hold_d  = hold_q;
        unique case (state_q)
            StIdle: begin
                if (hold_q != '0) begin
                    hold_d = hold_q - HW'(1);
                end else if (ddr_init_done && (ddr_wr_req || ddr_rd_req)) begin
                    cnt_a_d = '0;
                    cnt_b_d = '0;
                    is_wr_d = ddr_wr_req;
                    if (ddr_wr_req) begin
                        base_d  = ddr_wraddr;
                        len_d   = CW'(wr_length);
                        state_d = (wr_length == '0) ? StDone : StWr;
                    end else begin
                        base_d  = ddr_rdaddr;
                        len_d   = CW'(rd_length);
                        state_d = (rd_length == '0) ? StDone : StRd;
                    end
                end
            end
            StWr: begin
                if (wr_ack) cnt_a_d = cnt_a_q + CW'(1);
                if (wr_pop) begin
                    cnt_b_d = cnt_b_q + CW'(1);
                    if (cnt_b_q + CW'(1) == len_q) state_d = StDone;
                end
            end
            StRd: begin
                if (rd_en && mem_rdy) cnt_a_d = cnt_a_q + CW'(1);
                if (rd_accept) cnt_b_d = cnt_b_q + CW'(1);
                // Leaves one cycle after the last word was accepted, i.e. after the last ack.
                if (cnt_b_q == len_q) state_d = StDone;
            end
            StDone: begin
                hold_d  = HW'(HOLDOFF);
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        occ_d  = occ_q;
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        unique case ({wr_push, wr_pop})
            2'b10: begin
                if (occ_q == 2'd0) buf0_d = ddr_din;
                else               buf1_d = ddr_din;
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                buf0_d = buf1_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    buf0_d = ddr_din;
                end else begin
                    buf0_d = buf1_q;
                    buf1_d = ddr_din;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            is_wr_q  <= 1'b0;
            base_q   <= '0;
            len_q    <= '0;
            cnt_a_q  <= '0;
            cnt_b_q  <= '0;
            ack_q    <= 1'b0;
            occ_q    <= '0;
            buf0_q   <= '0;
            buf1_q   <= '0;
            hold_q   <= '0;
            rd_ack_q <= 1'b0;
            dout_q   <= '0;
        end else begin
            state_q  <= state_d;
            is_wr_q  <= is_wr_d;
            base_q   <= base_d;
            len_q    <= len_d;
            cnt_a_q  <= cnt_a_d;
            cnt_b_q  <= cnt_b_d;
            ack_q    <= wr_ack;
            occ_q    <= occ_d;
            buf0_q   <= buf0_d;
            buf1_q   <= buf1_d;
            hold_q   <= hold_d;
            rd_ack_q <= rd_accept;
            if (rd_accept) dout_q <= mem_rd_data;
        end
    end

    always_comb begin
        ddr_wr_ack    = wr_ack;
        ddr_wr_finish = (state_q == StDone) && is_wr_q;
        ddr_rd_finish = (state_q == StDone) && !is_wr_q;
        ddr_rd_ack    = rd_ack_q;
        ddr_dout      = dout_q;
        mem_wr_en     = wr_en;
        mem_rd_en     = rd_en;
        mem_wdata     = wr_en ? buf0_q : '0;
        if (wr_en)      mem_addr = base_q + ADDR_W'(cnt_b_q);
        else if (rd_en) mem_addr = base_q + ADDR_W'(cnt_a_q);
        else            mem_addr = '0;
        busy          = (state_q != StIdle);
    end

endmodule

// File: tb/tb_ddr_burst_engine.sv
// Scoreboard bench for ddr_burst_engine: directed bursts against a FIFO and fixed-latency memory model.
module tb_ddr_burst_engine;

    localparam int AW  = 25;
    localparam int DW  = 32;
    localparam int LW  = 10;
    localparam int LAT = 5;

    logic          clk_ref = 1'b0;
    logic          rst_n;
    logic          ddr_init_done, ddr_wr_req, ddr_rd_req;
    logic [AW-1:0] ddr_wraddr, ddr_rdaddr;
    logic [LW-1:0] wr_length, rd_length;
    logic          ddr_wr_ack, ddr_wr_finish, ddr_rd_ack, ddr_rd_finish;
    logic [DW-1:0] ddr_din, ddr_dout, mem_wdata, mem_rd_data;
    logic          mem_wr_en, mem_rd_en, mem_rdy, mem_rd_valid, busy;
    logic [AW-1:0] mem_addr;

    always #5 clk_ref = ~clk_ref;

    ddr_burst_engine dut (
        .clk_ref       (clk_ref),
        .rst_n         (rst_n),
        .ddr_init_done (ddr_init_done),
        .ddr_wr_req    (ddr_wr_req),
        .ddr_wraddr    (ddr_wraddr),
        .wr_length     (wr_length),
        .ddr_wr_ack    (ddr_wr_ack),
        .ddr_din       (ddr_din),
        .ddr_wr_finish (ddr_wr_finish),
        .ddr_rd_req    (ddr_rd_req),
        .ddr_rdaddr    (ddr_rdaddr),
        .rd_length     (rd_length),
        .ddr_rd_ack    (ddr_rd_ack),
        .ddr_dout      (ddr_dout),
        .ddr_rd_finish (ddr_rd_finish),
        .mem_wr_en     (mem_wr_en),
        .mem_rd_en     (mem_rd_en),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdy       (mem_rdy),
        .mem_rd_valid  (mem_rd_valid),
        .mem_rd_data   (mem_rd_data),
        .busy          (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rdata_of(input logic [AW-1:0] a);
        return {7'h55, a};
    endfunction

    // Scoreboard queues
    logic [AW-1:0] exp_waddr[$];
    logic [DW-1:0] exp_wdata[$];
    logic [AW-1:0] exp_raddr[$];
    logic [DW-1:0] exp_rdata[$];
    bit            exp_fin[$];

    int acks = 0, writes = 0, fins = 0, rd_acks = 0;
    bit valid_prev = 0, ack_prev = 0, fin_prev = 0;

    // Monitor: compares every presented transaction against the queues.
    always @(negedge clk_ref) begin
        if (!rst_n) begin
            valid_prev = 0;
            ack_prev   = 0;
            fin_prev   = 0;
        end else begin
            if (ddr_wr_ack) acks++;
            chk_eq("cmd_exclusive", 64'(mem_wr_en & mem_rd_en), 0);
            if (mem_wr_en && mem_rdy) begin
                writes++;
                chk_eq("mem_write_expected", 64'(exp_waddr.size() != 0), 1);
                if (exp_waddr.size() != 0) begin
                    chk_eq("mem_wr_addr", 64'(mem_addr), 64'(exp_waddr.pop_front()));
                    chk_eq("mem_wr_data", 64'(mem_wdata), 64'(exp_wdata.pop_front()));
                end
            end
            chk_eq("skid_depth", 64'((acks - writes) <= 2), 1);
            if (mem_rd_en && mem_rdy) begin
                chk_eq("mem_read_expected", 64'(exp_raddr.size() != 0), 1);
                if (exp_raddr.size() != 0)
                    chk_eq("mem_rd_addr", 64'(mem_addr), 64'(exp_raddr.pop_front()));
            end
            if (ddr_rd_ack) begin
                rd_acks++;
                chk_eq("rd_ack_latency", 64'(valid_prev), 1);
                chk_eq("rd_ack_expected", 64'(exp_rdata.size() != 0), 1);
                if (exp_rdata.size() != 0)
                    chk_eq("rd_dout", 64'(ddr_dout), 64'(exp_rdata.pop_front()));
            end
            if (ddr_wr_finish || ddr_rd_finish) begin
                fins++;
                chk_eq("one_finish", 64'(ddr_wr_finish & ddr_rd_finish), 0);
                chk_eq("finish_expected", 64'(exp_fin.size() != 0), 1);
                if (exp_fin.size() != 0)
                    chk_eq("finish_type", 64'(ddr_wr_finish), 64'(exp_fin.pop_front()));
                if (ddr_rd_finish) chk_eq("rd_finish_after_ack", 64'(ack_prev), 1);
            end
            if (fin_prev) chk_eq("idle_after_finish", 64'(busy), 0);
            valid_prev = mem_rd_valid;
            ack_prev   = ddr_rd_ack;
            fin_prev   = ddr_wr_finish | ddr_rd_finish;
        end
    end

    // Write-FIFO and fixed-latency memory model.
    logic [DW-1:0] fifo_base = '0;
    int            fifo_idx = 0;
    bit            rdy_toggle = 0;
    bit            s_pop, s_cmd;
    logic [AW-1:0] s_addr;
    logic          pipe_v [LAT];
    logic [AW-1:0] pipe_a [LAT];

    initial for (int i = 0; i < LAT; i++) begin pipe_v[i] = 0; pipe_a[i] = '0; end

    always begin
        @(negedge clk_ref);
        s_pop  = ddr_wr_ack;
        s_cmd  = mem_rd_en && mem_rdy;
        s_addr = mem_addr;
        @(posedge clk_ref);
        #1;
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) pipe_v[i] = 0;
            mem_rd_valid = 0;
        end else begin
            if (s_pop) begin
                ddr_din = fifo_base + DW'(fifo_idx);
                fifo_idx++;
            end
            for (int i = LAT - 1; i > 0; i--) begin
                pipe_v[i] = pipe_v[i-1];
                pipe_a[i] = pipe_a[i-1];
            end
            pipe_v[0]    = s_cmd;
            pipe_a[0]    = s_addr;
            mem_rd_valid = pipe_v[LAT-1];
            mem_rd_data  = rdata_of(pipe_a[LAT-1]);
            if (rdy_toggle) mem_rdy = !mem_rdy;
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(negedge clk_ref); #1; end
    endtask

    task automatic chk_zero(input string tag);
        chk_eq({tag, "_ctrl"}, 64'({busy, ddr_wr_ack, ddr_wr_finish, ddr_rd_ack, ddr_rd_finish,
                                    mem_wr_en, mem_rd_en}), 0);
        chk_eq({tag, "_addr"}, 64'(mem_addr), 0);
        chk_eq({tag, "_dout"}, 64'(ddr_dout), 0);
        chk_eq({tag, "_wdata"}, 64'(mem_wdata), 0);
    endtask

    task automatic push_burst(input bit is_wr, input logic [AW-1:0] base, input int len,
                              input logic [DW-1:0] dbase);
        for (int k = 0; k < len; k++) begin
            if (is_wr) begin
                exp_waddr.push_back(base + AW'(k));
                exp_wdata.push_back(dbase + DW'(k));
            end else begin
                exp_raddr.push_back(base + AW'(k));
                exp_rdata.push_back(rdata_of(base + AW'(k)));
            end
        end
        exp_fin.push_back(is_wr);
    endtask

    task automatic chk_drained(input string tag);
        chk_eq({tag, "_drained"}, 64'(exp_waddr.size() + exp_raddr.size() + exp_rdata.size()
                                      + exp_fin.size()), 0);
    endtask

    task automatic run_burst(input bit is_wr, input logic [AW-1:0] base, input int len,
                             input logic [DW-1:0] dbase, input bit do_push, input string tag);
        int fin0 = fins;
        int ack0 = acks;
        int t = 0;
        if (do_push) push_burst(is_wr, base, len, dbase);
        fifo_base = dbase;
        fifo_idx  = 0;
        if (is_wr) begin
            ddr_wraddr = base; wr_length = LW'(len); ddr_wr_req = 1;
        end else begin
            ddr_rdaddr = base; rd_length = LW'(len); ddr_rd_req = 1;
        end
        do begin step(1); t++; end while (!busy && t < 50);
        chk_eq({tag, "_start"}, 64'(busy), 1);
        ddr_wr_req = 0;
        ddr_rd_req = 0;
        t = 0;
        while (fins == fin0 && t < 3000) begin step(1); t++; end
        chk_eq({tag, "_finish_count"}, 64'(fins - fin0), 1);
        step(2);
        chk_drained(tag);
        if (is_wr) chk_eq({tag, "_acks"}, 64'(acks - ack0), 64'(len));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, gap, fin0;
        rst_n = 0; ddr_init_done = 1; ddr_wr_req = 0; ddr_rd_req = 0;
        ddr_wraddr = '0; ddr_rdaddr = '0; wr_length = '0; rd_length = '0;
        ddr_din = '0; mem_rdy = 1; mem_rd_valid = 0; mem_rd_data = '0;
        step(2);
        chk_zero("reset");
        rst_n = 1;
        step(2);

        // Write len 8, memory always ready
        run_burst(1, 25'h0000100, 8, 32'hD100_0000, 1, "wr8");

        // Write len 8 with mem_rdy toggling
        rdy_toggle = 1;
        run_burst(1, 25'h0000200, 8, 32'hD200_0000, 1, "wr8_stall");
        rdy_toggle = 0;
        mem_rdy = 1;
        step(4);

        // Read across the address wrap, hand-computed addresses and data
        exp_raddr.push_back(25'h1FFFFFE); exp_rdata.push_back(32'hABFF_FFFE);
        exp_raddr.push_back(25'h1FFFFFF); exp_rdata.push_back(32'hABFF_FFFF);
        exp_raddr.push_back(25'h0000000); exp_rdata.push_back(32'hAA00_0000);
        exp_raddr.push_back(25'h0000001); exp_rdata.push_back(32'hAA00_0001);
        exp_fin.push_back(0);
        run_burst(0, 25'h1FFFFFE, 4, '0, 0, "rd_wrap");
        step(4);

        // Simultaneous requests: write first, read only after the holdoff
        push_burst(1, 25'h0000300, 4, 32'hD400_0000);
        push_burst(0, 25'h0000380, 3, '0);
        fifo_base = 32'hD400_0000; fifo_idx = 0;
        ddr_wraddr = 25'h0000300; wr_length = 10'd4;
        ddr_rdaddr = 25'h0000380; rd_length = 10'd3;
        ddr_wr_req = 1; ddr_rd_req = 1;
        fin0 = fins; t = 0;
        while (fins == fin0 && t < 500) begin step(1); t++; end
        chk_eq("both_wr_finish_first", 64'(ddr_wr_finish), 1);
        gap = 0;
        do begin
            step(1); gap++;
            if (gap == 1) ddr_wr_req = 0;
        end while (!busy && gap < 20);
        chk_eq("holdoff_gap", 64'(gap), 4);
        ddr_rd_req = 0;
        t = 0;
        while (fins < fin0 + 2 && t < 500) begin step(1); t++; end
        chk_eq("both_finish_count", 64'(fins - fin0), 2);
        step(2);
        chk_drained("both");
        step(4);

        // Zero-length write
        run_burst(1, 25'h0000400, 0, 32'hD500_0000, 1, "wr_len0");
        step(4);

        // Init not done: request held, nothing happens
        ddr_init_done = 0; ddr_wraddr = 25'h0000440; wr_length = 10'd4; ddr_wr_req = 1;
        for (int i = 0; i < 8; i++) chk_eq("init_block_busy", 64'(busy | ddr_wr_ack), 0);
        step(8);
        chk_eq("init_block_busy_end", 64'(busy), 0);
        ddr_wr_req = 0; ddr_init_done = 1;
        step(4);

        // Reset in the middle of a len-16 read
        push_burst(0, 25'h0000500, 16, '0);
        ddr_rdaddr = 25'h0000500; rd_length = 10'd16; ddr_rd_req = 1;
        t = 0;
        do begin step(1); t++; end while (!busy && t < 50);
        ddr_rd_req = 0;
        fin0 = rd_acks; t = 0;
        while (rd_acks < fin0 + 6 && t < 200) begin step(1); t++; end
        chk_eq("mid_read_progress", 64'(rd_acks - fin0), 6);
        #2 rst_n = 0;
        #1 chk_zero("mid_reset");
        exp_waddr.delete(); exp_wdata.delete(); exp_raddr.delete();
        exp_rdata.delete(); exp_fin.delete();
        step(3);
        rst_n = 1;
        fin0 = fins;
        step(10);
        chk_eq("no_finish_after_reset", 64'(fins - fin0), 0);
        chk_eq("idle_after_reset", 64'(busy), 0);
        run_burst(0, 25'h0000600, 2, '0, 1, "rd2_after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ddr_burst_engine.md
Name: ddr_burst_engine

Overview:
- Responder side of the burst request/ack/finish handshake used by the DDR frame-buffer front-end.
- Accepts write-burst and read-burst requests with a base address and length.
- Write bursts: pops words from the requester's write FIFO through ddr_wr_ack and drives them onto a simple word-wide memory command port.
- Read bursts: issues read commands on the memory port and returns data through ddr_rd_ack/ddr_dout.
- Each burst ends with a one-cycle finish pulse.

Parameters:
ADDR_W, 25, word address width ({bank,row,column}).
DATA_W, 32, data word width.
LEN_W, 10, burst length width.
HOLDOFF, 2, IDLE cycles after a finish pulse during which requests are ignored.

Ports:
clk_ref  in  1  single clock for all logic.
rst_n  in  1  reset, asynchronous, active-low.
ddr_init_done  in  1  memory ready; no burst starts while low.
ddr_wr_req  in  1  write burst request (level).
ddr_wraddr  in  ADDR_W  write burst base address.
wr_length  in  LEN_W  write burst length in words.
ddr_wr_ack  out  1  write FIFO pop strobe; data arrives on ddr_din the following cycle.
ddr_din  in  DATA_W  write FIFO output data.
ddr_wr_finish  out  1  one-cycle pulse, write burst complete.
ddr_rd_req  in  1  read burst request (level).
ddr_rdaddr  in  ADDR_W  read burst base address.
rd_length  in  LEN_W  read burst length in words.
ddr_rd_ack  out  1  read FIFO push strobe.
ddr_dout  out  DATA_W  read data to read FIFO.
ddr_rd_finish  out  1  one-cycle pulse, read burst complete.
mem_wr_en  out  1  memory write command valid.
mem_rd_en  out  1  memory read command valid.
mem_addr  out  ADDR_W  memory command address.
mem_wdata  out  DATA_W  memory write data.
mem_rdy  in  1  memory accepts the command this cycle.
mem_rd_valid  in  1  memory read data valid.
mem_rd_data  in  DATA_W  memory read data.
busy  out  1  high in any state other than IDLE.

Behaviour:
Reset values:
- All outputs 0; state IDLE; counters, skid buffer and holdoff counter cleared.
- Reset asserted mid-burst aborts the burst immediately: no finish pulse, buffered words discarded.

States and transitions: IDLE, WR_BURST, RD_BURST, DONE.

IDLE:
- Requests are sampled only when ddr_init_done=1 and the holdoff counter is 0.
- If ddr_wr_req=1, latch ddr_wraddr and wr_length and go to WR_BURST. Write wins when both requests are high.
- Else if ddr_rd_req=1, latch ddr_rdaddr and rd_length and go to RD_BURST.
- A latched length of 0 goes straight to DONE (finish pulse, no acks, no memory commands).

WR_BURST:
- Counters: acks issued (ai), words captured, words written (ww).
- ddr_wr_ack=1 when ai<len and (skid occupancy + acks in flight) < 2.
- ddr_din is captured into the 2-entry skid buffer one cycle after each ack.
- mem_wr_en=1 whenever the buffer is non-empty, with mem_wdata = head word and mem_addr = base+ww.
- A word pops on mem_wr_en & mem_rdy.
- When ww reaches len, go to DONE.
- Exactly len acks and len memory writes per burst. The buffer never overflows; mem_rdy stalls are absorbed by withholding acks.

RD_BURST:
- Counters: commands issued (ci), words returned (rw).
- mem_rd_en=1 while ci<len, with mem_addr = base+ci; ci increments on mem_rdy.
- Commands and returned data overlap.
- Registered return path: ddr_rd_ack <= mem_rd_valid, ddr_dout <= mem_rd_data (1-cycle latency). No backpressure toward the read FIFO.
- When rw reaches len, go to DONE in the cycle after the last ddr_rd_ack.
- mem_rd_valid outside RD_BURST, or beyond len words, is ignored.

DONE:
- One cycle: pulse ddr_wr_finish or ddr_rd_finish according to the burst type.
- Load the holdoff counter with HOLDOFF, then return to IDLE.
- The holdoff absorbs the requester's registered request, which stays stale for one cycle after finish.

Arithmetic:
- Address = base + count, modulo 2^ADDR_W; it wraps silently at 2^ADDR_W.
- Counters are LEN_W+1 bits wide, so len=1023 completes.
- mem_wr_en and mem_rd_en are never high together.
- Exactly one of ddr_wr_finish or ddr_rd_finish is high per DONE cycle.

ddr_init_done falling:
- Has no effect on a burst in progress; it blocks only new bursts.

Test Plan:
- Write burst: base 0x0000100, len 8, mem_rdy=1 -> 8 acks; mem writes to 0x100..0x107 with FIFO data in order; one ddr_wr_finish pulse; busy low 1 cycle later.
- Write with mem_rdy toggling 1/0 -> never more than 2 words buffered; 8 writes in order; ack count 8; no lost or duplicated data.
- Read burst: base 0x1FFFFFE, len 4, fixed 5-cycle read latency -> addresses 0x1FFFFFE, 0x1FFFFFF, 0x0000000, 0x0000001; 4 ddr_rd_ack pulses each 1 cycle after mem_rd_valid; ddr_rd_finish 1 cycle after the last ack.
- ddr_wr_req and ddr_rd_req high together -> write burst first; requests held high through finish -> no new burst during the 2 holdoff cycles, then the read burst starts.
- Length 0 write request -> ddr_wr_finish pulse with zero acks and zero mem commands; ddr_init_done=0 with a request held -> stays IDLE and busy=0.
- rst_n asserted in the middle of a len-16 read -> all outputs 0 immediately; no finish pulse; a subsequent len-2 read completes normally.
